// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter and its bit timer.
// Holds the FSM state encoding, parity-mode constants and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Rounded to the nearest whole number of hwclk cycles per bit.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side valid/ready byte interface feeding the UART transmitter.
// The producer is the master; the transmitter is the slave and drives tx_ready.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the final cycle of each bit.
// Wraps to zero on tick so a new bit period starts on the following cycle.
module uart_bit_timer #(
    parameter int unsigned CNTR_W = 32,
    parameter int unsigned DIV    = 2
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam logic [CNTR_W-1:0] LAST = CNTR_W'(DIV - 1);

    if ($clog2(DIV) > CNTR_W) begin : g_bad_width
        $error("uart_bit_timer: CNTR_W too narrow for DIV");
    end

    logic [CNTR_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNTR_W'(1);
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, optional odd/even parity, 1 or 2 stop bits.
// All outputs are registered; the line idles high and each bit lasts DIV hwclk cycles.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned CNTR_W    = 32
) (
    input  logic          hwclk,
    input  logic          rst_n,
    uart_tx_cfg_if.slave  tx_if,
    output logic          ftdi_tx,
    output logic          busy,
    output logic          frame_sent
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: CLK_HZ/BAUD gives DIV < 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 ftdi_q, ftdi_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 fs_q, fs_d;

    logic accept;
    logic tick;

    // Timer is held at zero in idle, so the start bit gets a full DIV cycles.
    uart_bit_timer #(
        .CNTR_W (CNTR_W),
        .DIV    (DIV)
    ) u_bit_timer (
        .hwclk   (hwclk),
        .rst_n   (rst_n),
        .restart (state_q == StIdle),
        .enable  (state_q != StIdle),
        .tick    (tick)
    );

    assign accept         = tx_if.tx_valid && ready_q;
    assign tx_if.tx_ready = ready_q;
    assign ftdi_tx        = ftdi_q;
    assign busy           = busy_q;
    assign frame_sent     = fs_q;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        fs_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StStart;
                    data_d     = tx_if.tx_data;
                    par_d      = (PARITY == PAR_ODD) ? ~(^tx_if.tx_data) : ^tx_if.tx_data;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = (PARITY == PAR_NONE) ? StStop : StParity;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            StParity: begin
                if (tick) state_d = StStop;
            end
            StStop: begin
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d = StIdle;
                        fs_d    = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        ready_d = (state_d == StIdle);
        busy_d  = !ready_d;
        unique case (state_d)
            StStart:  ftdi_d = 1'b0;
            StData:   ftdi_d = data_d[bit_idx_d];
            StParity: ftdi_d = par_d;
            default:  ftdi_d = 1'b1;
        endcase
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            ftdi_q     <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            ftdi_q     <= ftdi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            fs_q       <= fs_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: five configurations share one clock and reset.
// Stimulus queues the expected line sequence; a monitor decodes each frame and compares.
module tb_uart_tx_cfg;

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          nbits;
        int          div;
        bit          abort;
    } exp_t;

    logic hwclk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;

    always #5 hwclk = ~hwclk;
    always @(posedge hwclk) cyc <= cyc + 1;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_d ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if_e ();

    logic [4:0] ftdi_w, busy_w, fs_w, ready_w;
    assign ready_w = {if_e.tx_ready, if_d.tx_ready, if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

    // a: 8N1 DIV 12; b: 8E1; c: 8O1; d: 8E2; e: 7N1 at 115200 (DIV 104)
    uart_tx_cfg #(.CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .CNTR_W(32)) u_a (
        .hwclk(hwclk), .rst_n(rst_n), .tx_if(if_a),
        .ftdi_tx(ftdi_w[0]), .busy(busy_w[0]), .frame_sent(fs_w[0]));
    uart_tx_cfg #(.CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .CNTR_W(32)) u_b (
        .hwclk(hwclk), .rst_n(rst_n), .tx_if(if_b),
        .ftdi_tx(ftdi_w[1]), .busy(busy_w[1]), .frame_sent(fs_w[1]));
    uart_tx_cfg #(.CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .CNTR_W(32)) u_c (
        .hwclk(hwclk), .rst_n(rst_n), .tx_if(if_c),
        .ftdi_tx(ftdi_w[2]), .busy(busy_w[2]), .frame_sent(fs_w[2]));
    uart_tx_cfg #(.CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .CNTR_W(32)) u_d (
        .hwclk(hwclk), .rst_n(rst_n), .tx_if(if_d),
        .ftdi_tx(ftdi_w[3]), .busy(busy_w[3]), .frame_sent(fs_w[3]));
    uart_tx_cfg #(.CLK_HZ(12000000), .BAUD(115200), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(1), .CNTR_W(32)) u_e (
        .hwclk(hwclk), .rst_n(rst_n), .tx_if(if_e),
        .ftdi_tx(ftdi_w[4]), .busy(busy_w[4]), .frame_sent(fs_w[4]));

    exp_t sb_q[$];
    bit   mon_busy = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int unsigned fs_cnt [5] = '{default: 0};
    int unsigned fs_last[5] = '{default: 0};
    int unsigned fs_prev[5] = '{default: 0};

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    always @(negedge hwclk) begin
        for (int k = 0; k < 5; k++) begin
            if (fs_w[k] === 1'b1) begin
                fs_cnt[k]  <= fs_cnt[k] + 1;
                fs_prev[k] <= fs_last[k];
                fs_last[k] <= cyc;
            end
        end
    end

    // Monitor: waits for a start bit on the instance named by the queue head, then
    // checks every bit holds for DIV cycles and frame_sent lands on the first idle cycle.
    initial begin : monitor
        exp_t e;
        int   k;
        int   hold;
        bit   aborted;
        bit   early_fs;
        forever begin
            @(negedge hwclk);
            if (sb_q.size() == 0) continue;
            k = sb_q[0].inst;
            if (ftdi_w[k] !== 1'b0) continue;
            e        = sb_q.pop_front();
            mon_busy = 1'b1;
            aborted  = 1'b0;
            early_fs = 1'b0;
            for (int b = 0; b < e.nbits && !aborted; b++) begin
                hold = 0;
                for (int c = 0; c < e.div; c++) begin
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (ftdi_w[k] === e.bits[b]) hold++;
                    if (fs_w[k] === 1'b1) early_fs = 1'b1;
                    @(negedge hwclk);
                end
                if (!aborted) check($sformatf("i%0d_bit%0d_hold", k, b), hold, e.div);
            end
            if (aborted) begin
                check($sformatf("i%0d_unexpected_abort", k), e.abort, 1);
            end else begin
                check($sformatf("i%0d_frame_sent", k), fs_w[k], 1);
                check($sformatf("i%0d_ready_at_end", k), ready_w[k], 1);
                check($sformatf("i%0d_idle_mark", k), ftdi_w[k], 1);
                check($sformatf("i%0d_early_frame_sent", k), early_fs, 0);
            end
            mon_busy = 1'b0;
        end
    end

    task automatic set_in(input int k, input bit v, input logic [8:0] d);
        case (k)
            0: begin if_a.tx_valid = v; if_a.tx_data = d[7:0]; end
            1: begin if_b.tx_valid = v; if_b.tx_data = d[7:0]; end
            2: begin if_c.tx_valid = v; if_c.tx_data = d[7:0]; end
            3: begin if_d.tx_valid = v; if_d.tx_data = d[7:0]; end
            default: begin if_e.tx_valid = v; if_e.tx_data = d[6:0]; end
        endcase
    endtask

    task automatic push(input int k, input logic [15:0] bits, input int n, input bit ab);
        exp_t e;
        e.inst  = k;
        e.bits  = bits;
        e.nbits = n;
        e.div   = (k == 4) ? 104 : 12;
        e.abort = ab;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge of the first start-bit cycle.
    task automatic send(input int k, input logic [8:0] d, input bit hold, input string tag);
        int n = 0;
        set_in(k, 1'b1, d);
        while (ready_w[k] !== 1'b1 && n < 2000) begin
            @(negedge hwclk);
            n++;
        end
        check({tag, "_ready"}, ready_w[k], 1);
        @(negedge hwclk);
        check({tag, "_start_latency"}, ftdi_w[k], 0);
        check({tag, "_busy"}, busy_w[k], 1);
        check({tag, "_ready_low"}, ready_w[k], 0);
        if (!hold) set_in(k, 1'b0, d);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge hwclk);
            n++;
        end
        check({tag, "_drained"}, (sb_q.size() == 0 && !mon_busy), 1);
        @(negedge hwclk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned fs0;
        int          hold;
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) set_in(k, 1'b0, 9'h0);
        repeat (3) @(negedge hwclk);
        check("rst_ftdi", ftdi_w, 5'h1f);
        check("rst_ready", ready_w, 5'h1f);
        check("rst_busy", busy_w, 5'h00);
        check("rst_frame_sent", fs_w, 5'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge hwclk);

        // 8N1 0x48: line 0,0,0,0,1,0,0,1,0,1
        fs0 = fs_cnt[0];
        push(0, {1'b1, 8'h48, 1'b0}, 10, 1'b0);
        send(0, 9'h48, 1'b0, "a48");
        wait_drain("a48", 400);
        check("a48_one_pulse", fs_cnt[0] - fs0, 1);

        // tx_data changes and a valid pulse mid-frame must not disturb the frame
        fs0 = fs_cnt[0];
        push(0, {1'b1, 8'h48, 1'b0}, 10, 1'b0);
        send(0, 9'h48, 1'b0, "a48b");
        repeat (20) @(negedge hwclk);
        set_in(0, 1'b1, 9'hFF);
        check("a_busy_not_ready", ready_w[0], 0);
        @(negedge hwclk);
        set_in(0, 1'b0, 9'hFF);
        wait_drain("a48b", 400);
        hold = 0;
        repeat (30) begin
            if (ftdi_w[0] === 1'b1) hold++;
            @(negedge hwclk);
        end
        check("a_no_second_frame", hold, 30);
        check("a48b_one_pulse", fs_cnt[0] - fs0, 1);

        // Asynchronous reset during data bit 3 (frame cycles 48..59)
        push(0, {1'b1, 8'h48, 1'b0}, 10, 1'b1);
        send(0, 9'h48, 1'b0, "a_rst");
        repeat (52) @(negedge hwclk);
        fs0 = fs_cnt[0];
        #1 rst_n = 1'b0;
        #1;
        check("a_rst_ftdi", ftdi_w[0], 1);
        check("a_rst_ready", ready_w[0], 1);
        check("a_rst_busy", busy_w[0], 0);
        repeat (3) @(negedge hwclk);
        rst_n = 1'b1;
        hold = 0;
        repeat (20) begin
            @(negedge hwclk);
            if (ftdi_w[0] === 1'b1) hold++;
        end
        check("a_rst_no_resume", hold, 20);
        check("a_rst_no_frame_sent", fs_cnt[0] - fs0, 0);
        push(0, {1'b1, 8'h48, 1'b0}, 10, 1'b0);
        send(0, 9'h48, 1'b0, "a_post_rst");
        wait_drain("a_post_rst", 400);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        push(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0);
        send(1, 9'h07, 1'b0, "b_even");
        wait_drain("b_even", 400);
        push(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0);
        send(2, 9'h07, 1'b0, "c_odd");
        wait_drain("c_odd", 400);

        // Back-to-back 8E2: 0x55 and 0xAA both have even parity bit 0
        fs0 = fs_cnt[3];
        push(3, {2'b11, 1'b0, 8'h55, 1'b0}, 12, 1'b0);
        push(3, {2'b11, 1'b0, 8'hAA, 1'b0}, 12, 1'b0);
        send(3, 9'h55, 1'b1, "d55");
        send(3, 9'hAA, 1'b0, "dAA");
        wait_drain("d_b2b", 800);
        check("d_two_pulses", fs_cnt[3] - fs0, 2);
        check("d_pulse_spacing", fs_last[3] - fs_prev[3], 145);

        // 7N1 at DIV 104
        push(4, {1'b1, 7'h41, 1'b0}, 9, 1'b0);
        send(4, 9'h41, 1'b0, "e41");
        wait_drain("e41", 2000);

        repeat (5) @(negedge hwclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
